// File: rtl/clock_gen.sv
// clock_gen: multi-channel fractional-rate clock-enable generator built from phase accumulators.
// Optional macro CLOCK_GEN_SQUARE_OUT_EN builds the per-channel CLK_OUT square-wave toggles.
module clock_gen #(
  parameter int  CHANNELS    = 2,
  parameter int  RATIO_W     = 8,
  parameter int  MULT_INIT   = 2,
  parameter int  DIV_INIT    = 10,
  parameter int  LOCK_CYCLES = 16,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK_IN,
  input  logic                RESET,
  output logic [CHANNELS-1:0] CE_OUT,
  output logic [CHANNELS-1:0] CLK_OUT,
  output logic                LOCKED,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [RATIO_W-1:0]  CFG_MULT,
  input  logic [RATIO_W-1:0]  CFG_DIV,
  output logic                CFG_ERR
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {SETTLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RATIO_W-1:0]   mult_q [CHANNELS];
  logic [RATIO_W-1:0]   mult_d [CHANNELS];
  logic [RATIO_W-1:0]   div_q  [CHANNELS];
  logic [RATIO_W-1:0]   div_d  [CHANNELS];
  logic [RATIO_W-1:0]   acc_q  [CHANNELS];
  logic [RATIO_W-1:0]   acc_d  [CHANNELS];
  logic [CHANNELS-1:0]  ce_q, ce_d;
  logic                 err_q, err_d;
  logic [RATIO_W:0]     sum;
  logic                 cfgOk;

  assign cfgOk = (CFG_DIV != '0) && (CFG_MULT != '0) && (CFG_MULT <= CFG_DIV) &&
                 (32'(CFG_CH) < CHANNELS);

  assign LOCKED    = (state_q == RUN);
  assign CFG_READY = (state_q == RUN);
  assign CE_OUT    = ce_q;
  assign CFG_ERR   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = mult_q;
    div_d   = div_q;
    acc_d   = acc_q;
    ce_d    = '0;
    err_d   = 1'b0;
    sum     = '0;
    case (state_q)
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        // Extra sum bit keeps acc+MULT from wrapping before the DIV compare
        for (int c = 0; c < CHANNELS; c++) begin
          sum = {1'b0, acc_q[c]} + {1'b0, mult_q[c]};
          if (sum >= {1'b0, div_q[c]}) begin
            acc_d[c] = acc_q[c] + mult_q[c] - div_q[c];
            ce_d[c]  = 1'b1;
          end else begin
            acc_d[c] = acc_q[c] + mult_q[c];
          end
        end
        if (CFG_VALID) begin
          if (cfgOk) begin
            mult_d[CFG_CH] = CFG_MULT;
            div_d[CFG_CH]  = CFG_DIV;
            for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
            cnt_d   = '0;
            ce_d    = '0;
            state_d = SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      ce_q    <= '0;
      err_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        mult_q[c] <= RATIO_W'(MULT_INIT);
        div_q[c]  <= RATIO_W'(DIV_INIT);
        acc_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      err_q   <= err_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mult_q[c] <= mult_d[c];
        div_q[c]  <= div_d[c];
        acc_q[c]  <= acc_d[c];
      end
    end
  end

`ifdef CLOCK_GEN_SQUARE_OUT_EN
  logic [CHANNELS-1:0] sq_q, sq_d;

  // Clearing on the next state keeps CLK_OUT low from the very edge that enters SETTLE
  always_comb begin
    sq_d = '0;
    if (state_d == RUN) sq_d = sq_q ^ ce_q;
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) sq_q <= '0;
    else       sq_q <= sq_d;
  end

  assign CLK_OUT = sq_q;
`else
  assign CLK_OUT = '0;
`endif

endmodule
